lsu_agu: RTL and testbench
==========================

LSU_AGU -- requirements
Module: lsu_agu

Interface
REQ-001 Parameter QDEPTH, default 2, power of two >=2: request queue entries.
REQ-002 Parameter TDEPTH, default 4, power of two >=2: outstanding-op tracker entries.
REQ-003 clk  in  1  clock; all state updates on posedge clk.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 req_valid  in  1  memory op offered by issue stage.
REQ-006 req_ready  out  1  op accepted when req_valid && req_ready.
REQ-007 req_opc  in  4  bit3 = store, bits2:0 = funct3.
REQ-008 req_base, req_imm  in  32 each  rs1 value, sign-extended offset.
REQ-009 req_wdata  in  32  store data (rs2).
REQ-010 req_rd  in  5  load destination register.
REQ-011 flush  in  1  discard unissued ops and pending exception.
REQ-012 lsu_p  out  lsu_pkt_t  {valid, opc, addr, wdata} to LSU address phase.
REQ-013 lsu_addr_wait  in  1  LSU cannot take a packet this cycle.
REQ-014 lsu_resp_valid  in  1  LSU completed one op (load or store), in issue order.
REQ-015 lsu_rdata  in  32  load result, valid with lsu_resp_valid.
REQ-016 wb_valid / wb_rd / wb_data  out  1/5/32  register writeback.
REQ-017 exc_valid / exc_addr / exc_store  out  1/32/1  misaligned or illegal access.
REQ-018 resp_err  out  1  sticky: response arrived with tracker empty.

Function
REQ-019 Effective address = req_base + req_imm modulo 2^32, computed at acceptance, stored in queue.
REQ-020 req_ready = (queue count < QDEPTH) && !flush && !exc_valid.
REQ-021 Faulting op: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0; load funct3 in {3,6,7}; store funct3 >2.
REQ-022 Faulting op is accepted but not enqueued; next cycle exc_valid=1, exc_addr=address, exc_store=opc[3]; held until flush.
REQ-023 Non-faulting op enqueued; earliest lsu_p.valid the cycle after acceptance (1-cycle latency).
REQ-024 lsu_p.valid = queue non-empty && !lsu_addr_wait && tracker not full; fields driven from queue head.
REQ-025 Head popped in every cycle lsu_p.valid=1; queue order strictly FIFO; pointers wrap modulo QDEPTH.
REQ-026 Same-cycle push and pop permitted; count unchanged.
REQ-027 On each pop, tracker pushes {is_load=!opc[3], rd}.
REQ-028 On lsu_resp_valid, tracker pops head; wb_valid = lsu_resp_valid && head.is_load && head.rd!=0, combinational.
REQ-029 wb_rd = tracker head rd; wb_data = lsu_rdata, passed unmodified.
REQ-030 Tracker push and pop in same cycle permitted; "tracker full" evaluated before that cycle's pop.
REQ-031 lsu_resp_valid with tracker empty: no pop, wb_valid=0, resp_err set until rst.
REQ-032 flush: queue emptied and exc_valid cleared next cycle; lsu_p.valid forced 0 in flush cycle; tracker untouched (issued ops still complete).
REQ-033 flush with req_valid same cycle: request not accepted.

Reset
REQ-034 On rst: queue and tracker empty, pointers 0, lsu_p.valid=0, exc_valid=0, resp_err=0, wb_valid=0; req_ready=1 the cycle after rst deasserts.
REQ-035 rst mid-operation discards all queued and outstanding ops; no wb_valid for them.
REQ-036 Non-valid data fields (addr, wdata, exc_addr) need no reset.

Verification
REQ-037 LW base=0x1000 imm=0x8, rd=5; LSU model returns 0xDEADBEEF 2 cycles after issue -> lsu_p.addr=0x1008 one cycle after accept; wb_valid, wb_rd=5, wb_data=0xDEADBEEF.
REQ-038 SH base=0x2001 imm=0 -> not issued; exc_valid=1, exc_addr=0x2001, exc_store=1; req_ready=0 until flush; flush clears.
REQ-039 lsu_addr_wait held 1; three back-to-back ops -> two accepted, req_ready=0; release wait -> issued in order, one per cycle.
REQ-040 SW then LB rd=0 then LBU rd=7 -> three responses; only third produces wb_valid with wb_rd=7.
REQ-041 Base 0xFFFFFFFC, imm 0x8 -> addr 0x00000004 (wrap), no exception.
REQ-042 Response pulse with tracker empty -> resp_err=1, stays 1 until rst; flush during queued op -> op never appears on lsu_p.

Source files
------------

// File: rtl/lsu_agu_if.sv
// Shared packet type and the issue/LSU/writeback bundle of the address generation unit.
// The master side is the issue stage plus LSU environment; the slave side is lsu_agu.
// Outputs of the AGU are inputs of the master modport and vice versa.
package lsu_agu_pkg;
  typedef struct packed {
    logic        valid;
    logic [3:0]  opc;
    logic [31:0] addr;
    logic [31:0] wdata;
  } lsu_pkt_t;
endpackage

interface lsu_agu_if;
  import lsu_agu_pkg::*;

  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_opc;
  logic [31:0] req_base;
  logic [31:0] req_imm;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        flush;

  lsu_pkt_t    lsu_p;
  logic        lsu_addr_wait;
  logic        lsu_resp_valid;
  logic [31:0] lsu_rdata;

  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        exc_valid;
  logic [31:0] exc_addr;
  logic        exc_store;
  logic        resp_err;

  modport master (
    output req_valid, req_opc, req_base, req_imm, req_wdata, req_rd, flush,
    output lsu_addr_wait, lsu_resp_valid, lsu_rdata,
    input  req_ready, lsu_p, wb_valid, wb_rd, wb_data,
    input  exc_valid, exc_addr, exc_store, resp_err
  );

  modport slave (
    input  req_valid, req_opc, req_base, req_imm, req_wdata, req_rd, flush,
    input  lsu_addr_wait, lsu_resp_valid, lsu_rdata,
    output req_ready, lsu_p, wb_valid, wb_rd, wb_data,
    output exc_valid, exc_addr, exc_store, resp_err
  );
endinterface

// File: rtl/lsu_agu.sv
// Load/store address generation: computes base+imm, checks alignment/legality,
// queues legal ops and issues them in order to the LSU, tracking outstanding ops
// so in-order responses can be turned into register writebacks.
// Latency: one cycle from acceptance to lsu_p.valid. Backpressure: req_ready drops
// when the queue is full, on flush or while an exception is pending; issue stalls
// on lsu_addr_wait or a full tracker.
module lsu_agu
  import lsu_agu_pkg::*;
#(
  parameter int QDEPTH = 2,
  parameter int TDEPTH = 4
) (
  input logic        clk,
  input logic        rst,
  lsu_agu_if.slave   bus
);

  localparam int QAW = $clog2(QDEPTH);
  localparam int QCW = QAW + 1;
  localparam int TAW = $clog2(TDEPTH);
  localparam int TCW = TAW + 1;

  // request queue (data fields are not reset; occupancy is qualified by q_cnt)
  logic [3:0]     q_opc   [QDEPTH];
  logic [31:0]    q_addr  [QDEPTH];
  logic [31:0]    q_wdata [QDEPTH];
  logic [4:0]     q_dst   [QDEPTH];
  logic [QAW-1:0] q_wptr;
  logic [QAW-1:0] q_rptr;
  logic [QCW-1:0] q_cnt;

  // outstanding-op tracker
  logic           t_load  [TDEPTH];
  logic [4:0]     t_dst   [TDEPTH];
  logic [TAW-1:0] t_wptr;
  logic [TAW-1:0] t_rptr;
  logic [TCW-1:0] t_cnt;

  logic        exc_pend;
  logic [31:0] exc_addr_q;
  logic        exc_store_q;
  logic        err_q;

  logic [31:0] ea;
  logic [2:0]  f3;
  logic        is_store;
  logic        fault;
  logic        ready;
  logic        accept;
  logic        push;
  logic        issue;
  logic        t_full;
  logic        t_pop;
  lsu_pkt_t    pkt;

  assign ea       = bus.req_base + bus.req_imm;
  assign f3       = bus.req_opc[2:0];
  assign is_store = bus.req_opc[3];

  // Decode misaligned halfword/word accesses and unused funct3 encodings
  always_comb begin
    fault = 1'b0;
    if (is_store) begin
      case (f3)
        3'd0:    fault = 1'b0;
        3'd1:    fault = ea[0];
        3'd2:    fault = |ea[1:0];
        default: fault = 1'b1;
      endcase
    end else begin
      case (f3)
        3'd0, 3'd4: fault = 1'b0;
        3'd1, 3'd5: fault = ea[0];
        3'd2:       fault = |ea[1:0];
        default:    fault = 1'b1;
      endcase
    end
  end

  assign ready  = (q_cnt != QCW'(QDEPTH)) && !bus.flush && !exc_pend && !rst;
  assign accept = bus.req_valid && ready;
  assign push   = accept && !fault;

  // tracker fullness is judged before this cycle's response pop
  assign t_full = (t_cnt == TCW'(TDEPTH));
  assign issue  = (q_cnt != '0) && !bus.lsu_addr_wait && !t_full && !bus.flush && !rst;
  assign t_pop  = bus.lsu_resp_valid && (t_cnt != '0) && !rst;

  // Present the queue head to the LSU address phase
  always_comb begin
    pkt       = '0;
    pkt.valid = issue;
    pkt.opc   = q_opc[q_rptr];
    pkt.addr  = q_addr[q_rptr];
    pkt.wdata = q_wdata[q_rptr];
  end

  assign bus.req_ready = ready;
  assign bus.lsu_p     = pkt;
  assign bus.wb_valid  = t_pop && t_load[t_rptr] && (t_dst[t_rptr] != 5'd0);
  assign bus.wb_rd     = t_dst[t_rptr];
  assign bus.wb_data   = bus.lsu_rdata;
  assign bus.exc_valid = exc_pend;
  assign bus.exc_addr  = exc_addr_q;
  assign bus.exc_store = exc_store_q;
  assign bus.resp_err  = err_q;

  // Queue pointers and occupancy; flush drops everything not yet issued
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      q_wptr <= '0;
      q_rptr <= '0;
      q_cnt  <= '0;
    end else begin
      if (push)  q_wptr <= q_wptr + QAW'(1);
      if (issue) q_rptr <= q_rptr + QAW'(1);
      q_cnt <= q_cnt + QCW'(push) - QCW'(issue);
    end
  end

  // Queue storage written at the tail on acceptance
  always_ff @(posedge clk) begin
    if (push) begin
      q_opc[q_wptr]   <= bus.req_opc;
      q_addr[q_wptr]  <= ea;
      q_wdata[q_wptr] <= bus.req_wdata;
      q_dst[q_wptr]   <= bus.req_rd;
    end
  end

  // Tracker pointers and occupancy; flush leaves issued ops in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      t_wptr <= '0;
      t_rptr <= '0;
      t_cnt  <= '0;
    end else begin
      if (issue) t_wptr <= t_wptr + TAW'(1);
      if (t_pop) t_rptr <= t_rptr + TAW'(1);
      t_cnt <= t_cnt + TCW'(issue) - TCW'(t_pop);
    end
  end

  // Tracker storage records whether each issued op needs a writeback
  always_ff @(posedge clk) begin
    if (issue) begin
      t_load[t_wptr] <= !q_opc[q_rptr][3];
      t_dst[t_wptr]  <= q_dst[q_rptr];
    end
  end

  // Pending exception: set by a faulting acceptance, held until flush
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      exc_pend <= 1'b0;
    end else if (accept && fault) begin
      exc_pend <= 1'b1;
    end
  end

  // Exception payload captured alongside the pending flag
  always_ff @(posedge clk) begin
    if (accept && fault) begin
      exc_addr_q  <= ea;
      exc_store_q <= is_store;
    end
  end

  // Sticky flag for a response with nothing outstanding
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (bus.lsu_resp_valid && (t_cnt == '0)) begin
      err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lsu_agu.sv
// Bench for lsu_agu: directed scenarios with literal expectations plus a long
// randomized run, all checked every cycle against a queue-based reference model.
module tb_lsu_agu;
  import lsu_agu_pkg::*;

  localparam int QD = 2;
  localparam int TD = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lsu_agu_if bus();

  lsu_agu #(.QDEPTH(QD), .TDEPTH(TD)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit [3:0]  opc;
    bit [31:0] addr;
    bit [31:0] wdata;
    bit [4:0]  rd;
  } op_t;

  typedef struct {
    bit       is_load;
    bit [4:0] rd;
  } trk_t;

  op_t       mq[$];
  trk_t      mt[$];
  bit        m_exc;
  bit        m_exc_store;
  bit [31:0] m_exc_addr;
  bit        m_err;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic bit tb_fault(input bit [3:0] opc, input bit [31:0] a);
    int f;
    f = int'(opc[2:0]);
    if (opc[3]) begin
      if (f > 2) return 1'b1;
      if (f == 1) return a[0];
      if (f == 2) return a[1:0] != 2'b00;
      return 1'b0;
    end
    if (f == 3 || f == 6 || f == 7) return 1'b1;
    if (f == 1 || f == 5) return a[0];
    if (f == 2) return a[1:0] != 2'b00;
    return 1'b0;
  endfunction

  // Reference model: expected outputs at negedge, state advance at posedge
  initial begin : compare
    bit        e_ready, e_issue, e_tpop, e_wb, e_err, acc, flt;
    bit [31:0] ea;
    op_t       o;
    trk_t      t;
    forever begin
      @(negedge clk);
      e_issue = 1'b0; e_tpop = 1'b0; acc = 1'b0; flt = 1'b0; e_err = 1'b0;
      if (rst) begin
        chk("rst_lsu_valid", 32'(bus.lsu_p.valid), 32'd0);
        chk("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
      end else begin
        ea      = bus.req_base + bus.req_imm;
        e_ready = (mq.size() < QD) && !bus.flush && !m_exc;
        acc     = bus.req_valid && e_ready;
        flt     = tb_fault(bus.req_opc, ea);
        e_issue = (mq.size() > 0) && !bus.lsu_addr_wait && (mt.size() < TD) && !bus.flush;
        e_tpop  = bus.lsu_resp_valid && (mt.size() > 0);
        e_err   = bus.lsu_resp_valid && (mt.size() == 0);
        e_wb    = e_tpop && mt[0].is_load && (mt[0].rd != 5'd0);
        chk("req_ready", 32'(bus.req_ready), 32'(e_ready));
        chk("lsu_valid", 32'(bus.lsu_p.valid), 32'(e_issue));
        if (e_issue) begin
          chk("lsu_opc", 32'(bus.lsu_p.opc), 32'(mq[0].opc));
          chk("lsu_addr", bus.lsu_p.addr, mq[0].addr);
          chk("lsu_wdata", bus.lsu_p.wdata, mq[0].wdata);
        end
        chk("wb_valid", 32'(bus.wb_valid), 32'(e_wb));
        if (e_wb) begin
          chk("wb_rd", 32'(bus.wb_rd), 32'(mt[0].rd));
          chk("wb_data", bus.wb_data, bus.lsu_rdata);
        end
        chk("exc_valid", 32'(bus.exc_valid), 32'(m_exc));
        if (m_exc) begin
          chk("exc_addr", bus.exc_addr, m_exc_addr);
          chk("exc_store", 32'(bus.exc_store), 32'(m_exc_store));
        end
        chk("resp_err", 32'(bus.resp_err), 32'(m_err));
      end
      @(posedge clk);
      if (rst) begin
        mq.delete();
        mt.delete();
        m_exc = 1'b0;
        m_err = 1'b0;
      end else begin
        if (e_err) m_err = 1'b1;
        if (e_tpop) void'(mt.pop_front());
        if (e_issue) begin
          o = mq.pop_front();
          t.is_load = !o.opc[3];
          t.rd      = o.rd;
          mt.push_back(t);
        end
        if (bus.flush) begin
          mq.delete();
          m_exc = 1'b0;
        end else if (acc) begin
          if (flt) begin
            m_exc       = 1'b1;
            m_exc_addr  = ea;
            m_exc_store = bus.req_opc[3];
          end else begin
            o.opc   = bus.req_opc;
            o.addr  = ea;
            o.wdata = bus.req_wdata;
            o.rd    = bus.req_rd;
            mq.push_back(o);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input bit [3:0] opc, input bit [31:0] base, input bit [31:0] imm,
                         input bit [31:0] wdata, input bit [4:0] rd);
    bus.req_valid = 1'b1;
    bus.req_opc   = opc;
    bus.req_base  = base;
    bus.req_imm   = imm;
    bus.req_wdata = wdata;
    bus.req_rd    = rd;
  endtask

  task automatic send(input bit [3:0] opc, input bit [31:0] base, input bit [31:0] imm,
                      input bit [31:0] wdata, input bit [4:0] rd);
    bit done;
    done = 1'b0;
    set_req(opc, base, imm, wdata, rd);
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (bus.req_ready) done = 1'b1;
      tick();
    end
    bus.req_valid = 1'b0;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL send_timeout req_ready stayed 0 for 20 cycles, required 1");
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((mt.size() > 0 || mq.size() > 0) && n < 50) begin
      bus.lsu_resp_valid = (mt.size() > 0);
      bus.lsu_rdata      = $urandom;
      tick();
      n++;
    end
    bus.lsu_resp_valid = 1'b0;
    if (n >= 50) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout outstanding ops remain after 50 cycles, required none");
    end
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin : drive
    rst                = 1'b1;
    bus.req_valid      = 1'b0;
    bus.req_opc        = '0;
    bus.req_base       = '0;
    bus.req_imm        = '0;
    bus.req_wdata      = '0;
    bus.req_rd         = '0;
    bus.flush          = 1'b0;
    bus.lsu_addr_wait  = 1'b0;
    bus.lsu_resp_valid = 1'b0;
    bus.lsu_rdata      = '0;
    repeat (3) tick();
    rst = 1'b0;

    // reset state
    @(negedge clk);
    chk("reset_ready", 32'(bus.req_ready), 32'd1);
    chk("reset_lsu_valid", 32'(bus.lsu_p.valid), 32'd0);
    chk("reset_exc", 32'(bus.exc_valid), 32'd0);
    chk("reset_err", 32'(bus.resp_err), 32'd0);
    chk("reset_wb", 32'(bus.wb_valid), 32'd0);
    tick();

    // LW with response two cycles after issue
    set_req(4'b0010, 32'h1000, 32'h8, 32'h0, 5'd5);
    @(negedge clk);
    chk("lw_ready", 32'(bus.req_ready), 32'd1);
    tick();
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("lw_issue_valid", 32'(bus.lsu_p.valid), 32'd1);
    chk("lw_issue_addr", bus.lsu_p.addr, 32'h0000_1008);
    tick();
    tick();
    bus.lsu_resp_valid = 1'b1;
    bus.lsu_rdata      = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("lw_wb_valid", 32'(bus.wb_valid), 32'd1);
    chk("lw_wb_rd", 32'(bus.wb_rd), 32'd5);
    chk("lw_wb_data", bus.wb_data, 32'hDEAD_BEEF);
    tick();
    bus.lsu_resp_valid = 1'b0;

    // misaligned SH raises a held exception
    set_req(4'b1001, 32'h2001, 32'h0, 32'h55, 5'd0);
    tick();
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("sh_exc_valid", 32'(bus.exc_valid), 32'd1);
    chk("sh_exc_addr", bus.exc_addr, 32'h0000_2001);
    chk("sh_exc_store", 32'(bus.exc_store), 32'd1);
    chk("sh_ready", 32'(bus.req_ready), 32'd0);
    chk("sh_not_issued", 32'(bus.lsu_p.valid), 32'd0);
    tick();
    tick();
    @(negedge clk);
    chk("sh_exc_hold", 32'(bus.exc_valid), 32'd1);
    tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    @(negedge clk);
    chk("sh_exc_cleared", 32'(bus.exc_valid), 32'd0);
    chk("sh_ready_back", 32'(bus.req_ready), 32'd1);
    tick();

    // issue stalled: only two ops fit, then drain in order
    bus.lsu_addr_wait = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_req(4'b0010, 32'h3000, 32'(i * 4), 32'h0, 5'(10 + i));
      @(negedge clk);
      chk("bp_ready", 32'(bus.req_ready), 32'(i < 2));
      tick();
    end
    bus.lsu_addr_wait = 1'b0;
    @(negedge clk);
    chk("bp_issue0", bus.lsu_p.addr, 32'h0000_3000);
    chk("bp_issue0_ready", 32'(bus.req_ready), 32'd0);
    tick();
    @(negedge clk);
    chk("bp_issue1", bus.lsu_p.addr, 32'h0000_3004);
    tick();
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("bp_issue2_valid", 32'(bus.lsu_p.valid), 32'd1);
    chk("bp_issue2", bus.lsu_p.addr, 32'h0000_3008);
    tick();
    drain();

    // SW, LB rd=0, LBU rd=7: only the last writes back
    send(4'b1010, 32'h4000, 32'h0, 32'h1234, 5'd3);
    send(4'b0000, 32'h4001, 32'h0, 32'h0, 5'd0);
    send(4'b0100, 32'h4002, 32'h0, 32'h0, 5'd7);
    repeat (4) tick();
    for (int k = 0; k < 3; k++) begin
      bus.lsu_resp_valid = 1'b1;
      bus.lsu_rdata      = 32'hA0 + 32'(k);
      @(negedge clk);
      chk("seq_wb_valid", 32'(bus.wb_valid), 32'(k == 2));
      if (k == 2) chk("seq_wb_rd", 32'(bus.wb_rd), 32'd7);
      tick();
    end
    bus.lsu_resp_valid = 1'b0;

    // address wraps modulo 2^32
    set_req(4'b0010, 32'hFFFF_FFFC, 32'h8, 32'h0, 5'd9);
    tick();
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("wrap_valid", 32'(bus.lsu_p.valid), 32'd1);
    chk("wrap_addr", bus.lsu_p.addr, 32'h0000_0004);
    chk("wrap_exc", 32'(bus.exc_valid), 32'd0);
    tick();
    drain();

    // response with nothing outstanding sets a sticky error
    @(negedge clk);
    chk("err_before", 32'(bus.resp_err), 32'd0);
    tick();
    bus.lsu_resp_valid = 1'b1;
    @(negedge clk);
    chk("err_pulse_no_wb", 32'(bus.wb_valid), 32'd0);
    tick();
    bus.lsu_resp_valid = 1'b0;
    @(negedge clk);
    chk("err_set", 32'(bus.resp_err), 32'd1);
    repeat (3) tick();
    @(negedge clk);
    chk("err_sticky", 32'(bus.resp_err), 32'd1);
    tick();

    // flush while an op is queued; the simultaneous request is refused
    bus.lsu_addr_wait = 1'b1;
    send(4'b0010, 32'h5000, 32'h0, 32'h0, 5'd4);
    set_req(4'b0010, 32'h6000, 32'h0, 32'h0, 5'd6);
    bus.flush         = 1'b1;
    bus.lsu_addr_wait = 1'b0;
    @(negedge clk);
    chk("flush_ready", 32'(bus.req_ready), 32'd0);
    chk("flush_forces_idle", 32'(bus.lsu_p.valid), 32'd0);
    tick();
    bus.flush     = 1'b0;
    bus.req_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("flushed_op_gone", 32'(bus.lsu_p.valid), 32'd0);
      tick();
    end

    // randomized traffic including flushes, faults and occasional resets
    for (int c = 0; c < 3000; c++) begin
      bus.req_valid      = 1'($urandom_range(0, 1));
      bus.req_opc        = 4'($urandom);
      bus.req_base       = ($urandom_range(0, 1) == 0) ? ($urandom & 32'hFFFF_FFFC) : $urandom;
      bus.req_imm        = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 15));
      bus.req_wdata      = $urandom;
      bus.req_rd         = 5'($urandom);
      bus.flush          = ($urandom_range(0, 19) == 0) || (m_exc && $urandom_range(0, 3) == 0);
      bus.lsu_addr_wait  = ($urandom_range(0, 2) == 0);
      bus.lsu_resp_valid = (mt.size() > 0) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 49) == 0);
      bus.lsu_rdata      = $urandom;
      rst                = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst                = 1'b0;
    bus.req_valid      = 1'b0;
    bus.flush          = 1'b1;
    bus.lsu_addr_wait  = 1'b0;
    bus.lsu_resp_valid = 1'b0;
    tick();
    bus.flush = 1'b0;
    drain();

    // reset mid-operation discards outstanding loads
    send(4'b0010, 32'h7000, 32'h0, 32'h0, 5'd1);
    send(4'b0010, 32'h7004, 32'h0, 32'h0, 5'd2);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_ready", 32'(bus.req_ready), 32'd1);
    chk("midrst_err_clear", 32'(bus.resp_err), 32'd0);
    tick();
    bus.lsu_resp_valid = 1'b1;
    bus.lsu_rdata      = 32'h1111_2222;
    @(negedge clk);
    chk("midrst_no_wb", 32'(bus.wb_valid), 32'd0);
    tick();
    bus.lsu_resp_valid = 1'b0;
    @(negedge clk);
    chk("midrst_err", 32'(bus.resp_err), 32'd1);
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
